seq_pattern_det: RTL

SEQ_PATTERN_DET -- requirements
Module: seq_pattern_det

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_det_window.sv | 43 ++++
 rtl/seq_pattern_det.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Bits needed to hold a pattern length of 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Bit history plus length-masked comparator against the incoming beat.
// Latency: hit is combinational on in_bit and the stored history.
// Backpressure: none; history advances only when shift is asserted.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int  PAT_W = 4,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             in_bit,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  // The oldest PAT_W-1 bits are stored; the beat in flight completes the window.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] mask;

  assign win = {hist, in_bit};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
    end else if (shift) begin
      hist <= win[PAT_W-2:0];
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = (((win ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/seq_pattern_det.sv
// Serial MSB-first pattern detector with configurable length/overlap and a saturating match counter.
// Latency: match pulses one cycle after the completing accepted beat.
// Backpressure: none; in_valid gaps freeze all state, cfg_load drops a coincident beat.
module seq_pattern_det
  import seq_det_pkg::*;
#(
  parameter int  PAT_W = 4,
  parameter int  CNT_W = 8,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [LEN_W-1:0] fill_cnt, fill_nxt;
  logic             match_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cfg_ok, accept, hist_clr, hit, eligible;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign accept = in_valid && (state != IDLE) && !cfg_load;
  assign armed  = (state != IDLE);

  seq_det_window #(.PAT_W(PAT_W)) u_window (
    .clk     (clk),
    .rst     (rst),
    .clr     (hist_clr),
    .shift   (accept),
    .in_bit  (in_bit),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    match_nxt = 1'b0;
    hist_clr  = 1'b0;
    eligible  = 1'b0;
    if (cfg_load) begin
      hist_clr  = 1'b1;
      fill_nxt  = '0;
      state_nxt = cfg_ok ? FILL : IDLE;
    end else if (accept) begin
      eligible = (state == RUN) || (LEN_W'(fill_cnt + LEN_W'(1)) == len_q);
      if (state == FILL) begin
        fill_nxt = LEN_W'(fill_cnt + LEN_W'(1));
      end
      if (eligible) begin
        state_nxt = RUN;
        if (hit) begin
          match_nxt = 1'b1;
          // Non-overlapping mode restarts the window from scratch after a match.
          if (!ovl_q) begin
            state_nxt = FILL;
            fill_nxt  = '0;
            hist_clr  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_nxt = match_count;
    if (cnt_clr) begin
      cnt_nxt = match_nxt ? CNT_W'(1) : '0;
    end else if (match_nxt && !(&match_count)) begin
      cnt_nxt = CNT_W'(match_count + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      fill_cnt    <= '0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      state       <= state_nxt;
      fill_cnt    <= fill_nxt;
      match       <= match_nxt;
      match_count <= cnt_nxt;
      count_sat   <= &cnt_nxt;
      if (cfg_load && cfg_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
      end
    end
  end

endmodule
